hsi_mse_lib_ctrl: RTL and testbench

Sequencer for the `hsi_mse` datapath that classifies one hyperspectral pixel against a reference library. It reads the pixel vector and each library vector word by word from two synchronous memories and streams them back to back into `hsi_mse`. It collects one MSE result per library entry and reports the minimum MSE with the index of the first entry that reached it. It sits between the pixel/library buffers and the `hsi_mse` instance.

---
 rtl/hsi_mse_lib_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hsi_mse_lib_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hsi_mse_lib_ctrl.sv
// Scan sequencer for hsi_mse: streams the pixel vector against each library vector,
// then reports the smallest MSE and the index of the first entry that produced it.
module hsi_mse_lib_ctrl #(
    parameter int WORD_WIDTH    = 32,
    parameter int DATA_WIDTH    = 16,
    parameter int DATA_PER_WORD = WORD_WIDTH / DATA_WIDTH,
    parameter int HSI_BANDS     = 128,
    parameter int ELEMENTS      = HSI_BANDS / DATA_PER_WORD,
    parameter int ELEMENTS_ADDR = $clog2(ELEMENTS),
    parameter int LIB_SIZE      = 16,
    parameter int LIB_ADDR      = $clog2(LIB_SIZE)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [LIB_ADDR:0]                 num_refs,
    output logic                              pixel_rd_en,
    output logic [ELEMENTS_ADDR-1:0]          pixel_addr,
    input  logic [WORD_WIDTH-1:0]             pixel_data,
    output logic                              lib_rd_en,
    output logic [LIB_ADDR+ELEMENTS_ADDR-1:0] lib_addr,
    input  logic [WORD_WIDTH-1:0]             lib_data,
    output logic                              mse_start_vctr,
    output logic [WORD_WIDTH-1:0]             mse_element_a,
    output logic [WORD_WIDTH-1:0]             mse_element_b,
    output logic                              mse_element_valid,
    input  logic [WORD_WIDTH-1:0]             mse_in,
    input  logic                              mse_in_valid,
    output logic                              busy,
    output logic                              done,
    output logic [WORD_WIDTH-1:0]             min_mse,
    output logic [LIB_ADDR-1:0]               min_index
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [LIB_ADDR:0]        LIB_SIZE_C = (LIB_ADDR+1)'(LIB_SIZE);
    localparam logic [ELEMENTS_ADDR-1:0] ELEM_LAST  = ELEMENTS_ADDR'(ELEMENTS - 1);

    state_t                    state_q, state_d;
    logic [LIB_ADDR:0]         n_q, n_d;
    logic [ELEMENTS_ADDR-1:0]  elem_q, elem_d;
    logic [LIB_ADDR-1:0]       ref_q, ref_d;
    logic [LIB_ADDR:0]         cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]     min_q, min_d;
    logic [LIB_ADDR-1:0]       idx_q, idx_d;
    logic                      vld_q, sov_q;

    logic                      rd_en;
    logic                      elem_wrap;
    logic                      last_rd;
    logic                      collect;
    logic [LIB_ADDR:0]         n_clamp;

    assign rd_en     = (state_q == S_STREAM);
    assign elem_wrap = (elem_q == ELEM_LAST);
    assign last_rd   = rd_en && elem_wrap && ({1'b0, ref_q} == (n_q - 1'b1));
    assign n_clamp   = (num_refs > LIB_SIZE_C) ? LIB_SIZE_C : num_refs;

    // Results past the n-th, or outside an active scan, never touch the minimum.
    assign collect   = ((state_q == S_STREAM) || (state_q == S_DRAIN)) &&
                       mse_in_valid && (cnt_q < n_q);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        elem_d  = elem_q;
        ref_d   = ref_q;
        cnt_d   = cnt_q;
        min_d   = min_q;
        idx_d   = idx_q;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = n_clamp;
                    min_d   = '1;
                    idx_d   = '0;
                    cnt_d   = '0;
                    elem_d  = '0;
                    ref_d   = '0;
                    state_d = (n_clamp == '0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                if (elem_wrap) begin
                    elem_d = '0;
                    ref_d  = ref_q + 1'b1;
                end else begin
                    elem_d = elem_q + 1'b1;
                end
                if (last_rd) begin
                    ref_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (collect) begin
            cnt_d = cnt_q + 1'b1;
            if (mse_in < min_q) begin
                min_d = mse_in;
                idx_d = cnt_q[LIB_ADDR-1:0];
            end
        end

        // Finish the moment the n-th result is counted, even if it lands on the last read.
        if (((state_q == S_STREAM) && last_rd) || (state_q == S_DRAIN)) begin
            if (cnt_d == n_q) begin
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            elem_q  <= '0;
            ref_q   <= '0;
            cnt_q   <= '0;
            min_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            sov_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            elem_q  <= elem_d;
            ref_q   <= ref_d;
            cnt_q   <= cnt_d;
            min_q   <= min_d;
            idx_q   <= idx_d;
            vld_q   <= rd_en;
            sov_q   <= rd_en && (elem_q == '0);
        end
    end

    // Memory words arrive one cycle after the strobe, aligned with vld_q/sov_q.
    assign pixel_rd_en       = rd_en;
    assign lib_rd_en         = rd_en;
    assign pixel_addr        = elem_q;
    assign lib_addr          = {ref_q, elem_q};
    assign mse_element_a     = pixel_data;
    assign mse_element_b     = lib_data;
    assign mse_element_valid = vld_q;
    assign mse_start_vctr    = sov_q;
    assign busy              = (state_q != S_IDLE);
    assign min_mse           = min_q;
    assign min_index         = idx_q;

endmodule

// File: tb/tb_hsi_mse_lib_ctrl.sv
// Bench for hsi_mse_lib_ctrl: memory models, an hsi_mse stand-in (mocked or computed
// results) and an address scoreboard filled when each scan is started.
module tb_hsi_mse_lib_ctrl;
    localparam int WW   = 32;
    localparam int ELEM = 64;
    localparam int LIBS = 16;
    localparam int EA   = 6;
    localparam int LA   = 4;
    localparam int LAT  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [LA:0]       num_refs = '0;
    logic              pixel_rd_en, lib_rd_en;
    logic [EA-1:0]     pixel_addr;
    logic [LA+EA-1:0]  lib_addr;
    logic [WW-1:0]     pixel_data, lib_data;
    logic              mse_start_vctr, mse_element_valid;
    logic [WW-1:0]     mse_element_a, mse_element_b;
    logic [WW-1:0]     mse_in;
    logic              mse_in_valid;
    logic              busy, done;
    logic [WW-1:0]     min_mse;
    logic [LA-1:0]     min_index;

    always #5 clk = ~clk;

    hsi_mse_lib_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_refs(num_refs),
        .pixel_rd_en(pixel_rd_en), .pixel_addr(pixel_addr), .pixel_data(pixel_data),
        .lib_rd_en(lib_rd_en), .lib_addr(lib_addr), .lib_data(lib_data),
        .mse_start_vctr(mse_start_vctr), .mse_element_a(mse_element_a),
        .mse_element_b(mse_element_b), .mse_element_valid(mse_element_valid),
        .mse_in(mse_in), .mse_in_valid(mse_in_valid), .busy(busy), .done(done),
        .min_mse(min_mse), .min_index(min_index)
    );

    // Synchronous memories: data one cycle after the strobe
    logic [WW-1:0] pix_mem [ELEM];
    logic [WW-1:0] lib_mem [LIBS*ELEM];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_data <= '0;
            lib_data   <= '0;
        end else begin
            if (pixel_rd_en) pixel_data <= pix_mem[pixel_addr];
            if (lib_rd_en)   lib_data   <= lib_mem[lib_addr];
        end
    end

    // hsi_mse stand-in: mean of squared band differences, or mocked per-vector values
    bit                    mock_mode = 1'b1;
    logic [15:0][WW-1:0]   mock_res = '0;
    logic [LAT-1:0]        pv_q;
    logic [WW-1:0]         pd_q [LAT];
    logic [WW-1:0]         acc_q, acc_base, acc_new;
    int                    wcnt_q, vec_q, wpos;
    logic                  inj_valid = 1'b0;
    logic [WW-1:0]         inj_val = '0;

    function automatic logic [WW-1:0] sqd(input logic [WW-1:0] a, input logic [WW-1:0] b);
        int d0, d1;
        d0 = int'(a[15:0]) - int'(b[15:0]);
        d1 = int'(a[31:16]) - int'(b[31:16]);
        return WW'(d0 * d0 + d1 * d1);
    endfunction

    assign acc_base = mse_start_vctr ? '0 : acc_q;
    assign acc_new  = acc_base + sqd(mse_element_a, mse_element_b);
    assign wpos     = mse_start_vctr ? 0 : wcnt_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q   <= '0;
            acc_q  <= '0;
            wcnt_q <= 0;
            vec_q  <= 0;
            for (int i = 0; i < LAT; i++) pd_q[i] <= '0;
        end else begin
            pv_q <= {pv_q[LAT-2:0], 1'b0};
            for (int i = 1; i < LAT; i++) pd_q[i] <= pd_q[i-1];
            if (start && !busy) vec_q <= 0;
            if (mse_element_valid) begin
                acc_q  <= acc_new;
                wcnt_q <= wpos + 1;
                if (wpos == ELEM - 1) begin
                    pv_q[0] <= 1'b1;
                    pd_q[0] <= mock_mode ? mock_res[vec_q[3:0]] : (acc_new >> 7);
                    vec_q   <= vec_q + 1;
                end
            end
        end
    end

    assign mse_in_valid = pv_q[LAT-1] | inj_valid;
    assign mse_in       = inj_valid ? inj_val : pd_q[LAT-1];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    logic [LA+EA-1:0] exp_q [$];

    task automatic run_scan(input int nreq, input bit poke, input int abort_at,
                            input logic [WW-1:0] exp_min, input int exp_idx);
        int n, cyc, done_cyc, nth_cyc, nres, first_rd, valid_cnt, done_cnt, limit;
        logic [LA+EA-1:0] e;
        n = (nreq > LIBS) ? LIBS : nreq;
        exp_q.delete();
        for (int r = 0; r < n; r++)
            for (int w = 0; w < ELEM; w++) exp_q.push_back((LA+EA)'(r * ELEM + w));
        @(negedge clk);
        start    = 1'b1;
        num_refs = nreq[LA:0];
        cyc = 0; done_cyc = -1; nth_cyc = -1; nres = 0; first_rd = -1;
        valid_cnt = 0; done_cnt = 0;
        limit = n * ELEM + 100;
        while (cyc < limit && !(done_cyc >= 0 && cyc >= done_cyc + 2)) begin
            @(negedge clk);
            cyc++;
            if (pixel_rd_en || lib_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL extra_read: lib_addr=%0d pixel_addr=%0d, expected no read", lib_addr, pixel_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("read", {pixel_rd_en, lib_rd_en, lib_addr, pixel_addr}, {2'b11, e, e[EA-1:0]});
                end
            end
            if (mse_element_valid) begin
                chk("word", {mse_start_vctr, mse_element_a, mse_element_b},
                    {(valid_cnt % ELEM) == 0, pixel_data, lib_data});
                valid_cnt++;
            end else if (mse_start_vctr) begin
                checks++;
                $display("FAIL start_vctr: high without valid at cycle %0d, expected low", cyc);
            end
            if (mse_in_valid && nres < n) begin
                nres++;
                if (nres == n) nth_cyc = cyc;
            end
            if (cyc == 1) chk("busy_start", busy, 1'b1);
            if (done_cyc >= 0 && cyc == done_cyc + 1) chk("busy_after_done", busy, 1'b0);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    chk("busy_at_done", busy, 1'b1);
                end
            end
            if (abort_at > 0 && cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("async_reset_outputs",
                    {pixel_rd_en, lib_rd_en, pixel_addr, lib_addr, mse_start_vctr,
                     mse_element_valid, busy, done, min_mse, min_index}, '0);
                start = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("reset_quiet", {done, busy, pixel_rd_en}, '0);
                end
                rst_n = 1'b1;
                @(negedge clk);
                chk("post_reset_idle", {done, busy, pixel_rd_en, min_mse}, '0);
                return;
            end
            inj_valid = (done && done_cyc == cyc);
            inj_val   = '0;
            start     = 1'b0;
            if (poke && (cyc == 51 || cyc == n * ELEM + 2)) begin
                start    = 1'b1;
                num_refs = 5'd1;
            end
        end
        inj_valid = 1'b0;
        start     = 1'b0;
        chk("reads_left", exp_q.size(), 0);
        chk("first_read_cycle", first_rd, (n > 0) ? 1 : -1);
        chk("valid_count", valid_cnt, n * ELEM);
        chk("done_count", done_cnt, 1);
        chk("done_cycle", done_cyc, (n > 0) ? nth_cyc + 1 : 1);
        chk("min_mse", min_mse, exp_min);
        chk("min_index", min_index, exp_idx);
    endtask

    typedef struct {
        int                  nreq;
        logic [15:0][WW-1:0] res;
        logic [WW-1:0]       exp_min;
        int                  exp_idx;
    } row_t;

    row_t tbl [6];

    initial begin
        tbl[0].nreq = 4;  tbl[0].res = '0;
        tbl[0].res[0] = 20; tbl[0].res[1] = 7; tbl[0].res[2] = 7; tbl[0].res[3] = 30;
        tbl[0].exp_min = 7; tbl[0].exp_idx = 1;
        tbl[1].nreq = 0;  tbl[1].res = '0; tbl[1].exp_min = '1; tbl[1].exp_idx = 0;
        tbl[2].nreq = 20; tbl[2].res = '0;
        for (int k = 0; k < 16; k++) tbl[2].res[k] = WW'(1000 - 10 * k);
        tbl[2].exp_min = 850; tbl[2].exp_idx = 15;
        tbl[3].nreq = 3;  tbl[3].res = '0;
        tbl[3].res[0] = 5; tbl[3].res[1] = 5; tbl[3].res[2] = 5;
        tbl[3].exp_min = 5; tbl[3].exp_idx = 0;
        tbl[4].nreq = 1;  tbl[4].res = '0; tbl[4].res[0] = '1;
        tbl[4].exp_min = '1; tbl[4].exp_idx = 0;
        tbl[5].nreq = 2;  tbl[5].res = '0; tbl[5].res[0] = 40; tbl[5].res[1] = 3;
        tbl[5].exp_min = 3; tbl[5].exp_idx = 1;

        for (int w = 0; w < ELEM; w++) begin
            pix_mem[w] = {16'(w * 37 + 100), 16'(w * 11 + 5)};
            for (int r = 0; r < LIBS; r++)
                lib_mem[r * ELEM + w] = (r == 5) ? pix_mem[w]
                                      : {16'(w * 37 + 103), 16'(w * 11 + 8)};
        end

        #1;
        chk("reset_state",
            {pixel_rd_en, lib_rd_en, pixel_addr, lib_addr, mse_start_vctr,
             mse_element_valid, busy, done, min_mse, min_index}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            mock_res = tbl[i].res;
            run_scan(tbl[i].nreq, 1'b0, 0, tbl[i].exp_min, tbl[i].exp_idx);
        end

        // Restart requests mid-stream and in DRAIN are ignored
        mock_res = '0;
        mock_res[0] = 9; mock_res[1] = 4; mock_res[2] = 6;
        run_scan(3, 1'b1, 0, 4, 1);

        // Reset in the middle of a scan, then a clean scan
        run_scan(4, 1'b0, 100, '0, 0);
        mock_res = '0;
        mock_res[0] = 12; mock_res[1] = 11;
        run_scan(2, 1'b0, 0, 11, 1);

        // Computed MSE: entry 5 matches the pixel, the rest are off by 3 per band
        mock_mode = 1'b0;
        run_scan(8, 1'b0, 0, 0, 5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
